nearest_centroid_ctrl: RTL
==========================

// Module: nearest_centroid_ctrl
// PURPOSE
// Sequences one shared distance_calc datapath across all active centroids for each incoming point.
// Accepts a point, reads centroids 0..K-1 from centroid memory, and feeds each one with the point to distance_calc.
// Tracks the running minimum L1 distance and returns the nearest centroid index and distance.
// Sits between the point stream and the centroid-update/accumulate stage of the k-means core.
// PARAMETERS
// dataWidth        91  packed point/centroid width (7 coords x cordinate_width)
// cordinate_width  13  unsigned coordinate width
// centroid_num     8   max centroids; centroid memory depth
// idx_width        3   centroid index width, $clog2(centroid_num)
// dist_width       16  used distance width (cordinate_width+3: sum of 7 coords)
// PORTS
// clk          in   1               clock, all state on rising edge
// rst_n        in   1               async active-low reset
// point_valid  in   1               input point valid
// point_ready  out  1               controller can accept a point
// point_data   in   dataWidth       point coordinates
// k_active     in   idx_width+1     active centroid count, sampled at point accept
// flush        in   1               sync abort of current point, back to IDLE
// cent_rd_en   out  1               centroid memory read strobe
// cent_rd_addr out  idx_width       centroid memory address
// cent_rd_data in   dataWidth       read data, valid 1 cycle after cent_rd_en
// dc_first     out  dataWidth       to distance_calc first_point (latched point)
// dc_second    out  dataWidth       to distance_calc second_point (= cent_rd_data)
// dc_distance  in   dataWidth       from distance_calc; bits [dist_width-1:0] used
// res_valid    out  1               result valid
// res_ready    in   1               downstream accepts result
// res_idx      out  idx_width       nearest centroid index
// res_dist     out  dist_width      its L1 distance
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; point_ready=1; cent_rd_en=0; cent_rd_addr=0; res_valid=0; res_idx=0; res_dist=0; point reg=0.
// - FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
// - IDLE: point_ready=1. On point_valid&point_ready: latch point_data, K=k_active (0 or >centroid_num -> centroid_num),
//   addr=0, min_dist=all-ones, min_idx=0 -> RUN.
// - RUN: point_ready=0; cent_rd_en=1, cent_rd_addr=addr, addr++ each cycle; issuing addr K-1 -> DRAIN next cycle.
// - rd_vld pipeline reg = cent_rd_en delayed 1 cycle, with rd_idx = addr delayed 1 cycle.
// - Compare in any cycle with rd_vld=1: if dc_distance[dist_width-1:0] < min_dist (strict),
//   min_dist<=distance, min_idx<=rd_idx. Ties keep lower index.
// - DRAIN: cent_rd_en=0; waits the cycle with the last rd_vld, then -> DONE with res_idx/res_dist loaded from final min.
// - Latency: accept at cycle T -> reads T+1..T+K -> res_valid first high at T+K+2.
// - DONE: res_valid=1; res_idx/res_dist stable until res_valid&res_ready; then res_valid=0 -> IDLE (point_ready=1 next cycle; no overlap).
// - dc_first = latched point; dc_second = cent_rd_data (combinational pass-through); dc_distance is combinational, sampled only when rd_vld=1.
// - flush: in any state, next cycle state=IDLE, cent_rd_en=0, rd_vld=0, res_valid=0; the pending result is dropped.
//   flush takes priority over point accept and res_ready.
// - Reset asserted mid-operation: immediate return to reset values; no partial result emitted.
// - Upper dc_distance bits above dist_width are ignored (always 0 for 7x13-bit coords).
// TESTING
// 1. K=8, point=0, centroid i all coords = 8-i -> res_idx=7, res_dist=7, res_valid at accept+10.
// 2. Tie: centroids 2 and 5 both distance 3, others larger -> res_idx=2, res_dist=3.
// 3. k_active=3, centroid 6 closest -> only addr 0..2 read; result from 0..2; k_active=0 -> all 8 read.
// 4. res_ready low 5 cycles -> res_idx/res_dist stable, point_ready=0; accept fires the cycle after handshake.
// 5. flush asserted in RUN at addr 4 -> no res_valid, IDLE next cycle; next point gives correct result.
// 6. rst_n pulsed low mid-RUN and in DONE -> all outputs at reset values asynchronously; clean restart.

Source files
------------

// File: rtl/nearest_centroid_ctrl.sv
// Nearest-centroid sequencer: streams centroids 0..K-1 through one shared distance_calc
// and returns the index/L1 distance of the closest centroid for each accepted point.
module nearest_centroid_ctrl #(
  parameter int dataWidth       = 91,
  parameter int cordinate_width = 13,
  parameter int centroid_num    = 8,
  parameter int idx_width       = 3,
  parameter int dist_width      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  point_valid,
  output logic                  point_ready,
  input  logic [dataWidth-1:0]  point_data,
  input  logic [idx_width:0]    k_active,
  input  logic                  flush,
  output logic                  cent_rd_en,
  output logic [idx_width-1:0]  cent_rd_addr,
  input  logic [dataWidth-1:0]  cent_rd_data,
  output logic [dataWidth-1:0]  dc_first,
  output logic [dataWidth-1:0]  dc_second,
  input  logic [dataWidth-1:0]  dc_distance,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [idx_width-1:0]  res_idx,
  output logic [dist_width-1:0] res_dist
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [idx_width:0] KMax = (idx_width+1)'(centroid_num);

  state_t                state;
  logic [dataWidth-1:0]  pt_q;
  logic [idx_width:0]    k_q;
  logic                  rd_vld;
  logic [idx_width-1:0]  rd_idx;
  logic [dist_width-1:0] min_dist;
  logic [idx_width-1:0]  min_idx;

  logic [dist_width-1:0] cur_dist;
  logic                  take;
  logic [dist_width-1:0] nxt_dist;
  logic [idx_width-1:0]  nxt_idx;
  logic                  last_addr;

  // Upper distance bits cannot be non-zero for in-range coordinates.
  logic unused_hi;
  logic [cordinate_width-1:0] unused_coord;
  assign unused_hi    = ^dc_distance[dataWidth-1:dist_width];
  assign unused_coord = pt_q[cordinate_width-1:0];

  assign dc_first  = pt_q;
  assign dc_second = cent_rd_data;

  // Strict less-than: on ties the earlier (lower) index is kept.
  assign cur_dist  = dc_distance[dist_width-1:0];
  assign take      = rd_vld && (cur_dist < min_dist);
  assign nxt_dist  = take ? cur_dist : min_dist;
  assign nxt_idx   = take ? rd_idx : min_idx;
  assign last_addr = ({1'b0, cent_rd_addr} == (k_q - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      point_ready  <= 1'b1;
      cent_rd_en   <= 1'b0;
      cent_rd_addr <= '0;
      res_valid    <= 1'b0;
      res_idx      <= '0;
      res_dist     <= '0;
      pt_q         <= '0;
      k_q          <= KMax;
      rd_vld       <= 1'b0;
      rd_idx       <= '0;
      min_dist     <= '1;
      min_idx      <= '0;
    end else if (flush) begin
      state       <= IDLE;
      point_ready <= 1'b1;
      cent_rd_en  <= 1'b0;
      rd_vld      <= 1'b0;
      res_valid   <= 1'b0;
    end else begin
      rd_vld <= cent_rd_en;
      rd_idx <= cent_rd_addr;
      if (rd_vld) begin
        min_dist <= nxt_dist;
        min_idx  <= nxt_idx;
      end
      case (state)
        IDLE: begin
          if (point_valid && point_ready) begin
            pt_q         <= point_data;
            k_q          <= (k_active == '0 || k_active > KMax) ? KMax : k_active;
            cent_rd_addr <= '0;
            cent_rd_en   <= 1'b1;
            min_dist     <= '1;
            min_idx      <= '0;
            point_ready  <= 1'b0;
            state        <= RUN;
          end
        end
        RUN: begin
          if (last_addr) begin
            cent_rd_en <= 1'b0;
            state      <= DRAIN;
          end else begin
            cent_rd_addr <= cent_rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          // Last compare folds straight into the result register.
          if (rd_vld) begin
            res_idx   <= nxt_idx;
            res_dist  <= nxt_dist;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            point_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
